float32_subtractor: RTL and testbench

//  Multi-cycle IEEE-754 binary32 subtractor, result = A - B, complementing float32_adder in the

---
 rtl/float32_subtractor.sv | 193 +++++++++++++++++++
 tb/tb_float32_subtractor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/float32_subtractor.sv
// float32_subtractor: multi-cycle IEEE-754 binary32 subtractor (result = a - b).
// Flush-to-zero on inputs, round-toward-zero, serial 1-bit/cycle alignment and
// normalisation shifts, valid/ready handshake with a single operation in flight.
module float32_subtractor #(
  parameter int unsigned ALIGN_LIMIT = 26,
  parameter logic [31:0] NAN_VALUE   = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK, DONE} stateType;

  localparam logic [7:0] ALIGN_CAP = 8'(ALIGN_LIMIT);

  stateType          state;
  logic              signX;
  logic              effSub;
  logic              specialHit;
  logic              zeroRes;
  logic              underflow;
  logic signed [9:0] expX;
  logic [26:0]       mantX;
  logic [26:0]       mantY;
  logic [27:0]       sum;
  logic [7:0]        alignCnt;
  logic [31:0]       specialVal;

  logic              signA, signB, zeroA, zeroB;
  logic              nanA, nanB, infA, infB;
  logic              bLarger, isSpecial;
  logic [7:0]        expA, expB, expBig, expSmall, expDiff, alignStart;
  logic [23:0]       mantA, mantB;
  logic [31:0]       specialCalc;
  logic [27:0]       sumComb;
  logic [27:0]       sumLeft;
  logic signed [9:0] expDown;

  // Operand decode, magnitude ordering and direct results for special inputs
  always_comb begin
    signA    = a[31];
    signB    = b[31];
    expA     = a[30:23];
    expB     = b[30:23];
    zeroA    = (expA == 8'd0);
    zeroB    = (expB == 8'd0);
    nanA     = (expA == 8'hFF) && (a[22:0] != 23'd0);
    nanB     = (expB == 8'hFF) && (b[22:0] != 23'd0);
    infA     = (expA == 8'hFF) && (a[22:0] == 23'd0);
    infB     = (expB == 8'hFF) && (b[22:0] == 23'd0);
    mantA    = zeroA ? '0 : {1'b1, a[22:0]};
    mantB    = zeroB ? '0 : {1'b1, b[22:0]};
    bLarger  = ((zeroA ? 31'd0 : a[30:0]) < (zeroB ? 31'd0 : b[30:0]));
    expBig   = bLarger ? expB : expA;
    expSmall = bLarger ? expA : expB;
    expDiff  = expBig - expSmall;
    alignStart = (expDiff > ALIGN_CAP) ? ALIGN_CAP : expDiff;
    isSpecial  = (expA == 8'hFF) || (expB == 8'hFF) || (zeroA && zeroB);
    if (nanA || nanB)
      specialCalc = NAN_VALUE;
    else if (infA && infB)
      specialCalc = (signA == signB) ? NAN_VALUE : {signA, 8'hFF, 23'd0};
    else if (infA)
      specialCalc = {signA, 8'hFF, 23'd0};
    else if (infB)
      specialCalc = {~signB, 8'hFF, 23'd0};
    else
      specialCalc = {signA & ~signB, 31'd0};
  end

  // Effective add/subtract and one-step left normalisation candidates
  always_comb begin
    sumComb = effSub ? ({1'b0, mantX} - {1'b0, mantY}) : ({1'b0, mantX} + {1'b0, mantY});
    sumLeft = {sum[26:0], 1'b0};
    expDown = expX - 10'sd1;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      signX      <= 1'b0;
      effSub     <= 1'b0;
      specialHit <= 1'b0;
      zeroRes    <= 1'b0;
      underflow  <= 1'b0;
      expX       <= '0;
      mantX      <= '0;
      mantY      <= '0;
      sum        <= '0;
      alignCnt   <= '0;
      specialVal <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            specialVal <= specialCalc;
            specialHit <= isSpecial;
            zeroRes    <= 1'b0;
            underflow  <= 1'b0;
            signX      <= bLarger ? ~signB : signA;
            effSub     <= (signA == signB);
            expX       <= signed'({2'b00, expBig});
            mantX      <= {bLarger ? mantB : mantA, 3'b000};
            mantY      <= {bLarger ? mantA : mantB, 3'b000};
            alignCnt   <= alignStart;
            // Specials still pass through PACK so the result register is loaded
            // in one place; that also provides the one-cycle special latency.
            if (isSpecial)
              state <= PACK;
            else if (alignStart == 8'd0)
              state <= ADD;
            else
              state <= ALIGN;
          end
        end
        ALIGN: begin
          // Dropped bits accumulate in bit 0; after ALIGN_LIMIT shifts a far
          // smaller operand has collapsed entirely into that sticky bit.
          mantY    <= {1'b0, mantY[26:2], mantY[1] | mantY[0]};
          alignCnt <= alignCnt - 8'd1;
          if (alignCnt == 8'd1)
            state <= ADD;
        end
        ADD: begin
          sum <= sumComb;
          if (sumComb == 28'd0) begin
            zeroRes <= 1'b1;
            state   <= PACK;
          end else if (sumComb[27] || !sumComb[26]) begin
            state <= NORM;
          end else begin
            state <= PACK;
          end
        end
        NORM: begin
          if (sum[27]) begin
            sum   <= {1'b0, sum[27:2], sum[1] | sum[0]};
            expX  <= expX + 10'sd1;
            state <= PACK;
          end else begin
            sum  <= sumLeft;
            expX <= expDown;
            if (expDown <= 10'sd0) begin
              underflow <= 1'b1;
              state     <= PACK;
            end else if (sumLeft[26]) begin
              state <= PACK;
            end
          end
        end
        PACK: begin
          if (specialHit)
            result <= specialVal;
          else if (zeroRes)
            result <= '0;
          else if (underflow)
            result <= {signX, 31'd0};
          else if (expX >= 10'sd255)
            result <= {signX, 31'h7F7FFFFF};
          else
            result <= {signX, expX[7:0], sum[25:3]};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float32_subtractor.sv
// Directed bench for float32_subtractor: vector table with expected results and
// latencies, plus backpressure and mid-operation reset sequences.
module tb_float32_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  float32_subtractor #(
    .ALIGN_LIMIT(26),
    .NAN_VALUE(32'h7FC00000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] expRes;
    int          expLat;
    string       name;
  } vecT;

  vecT vecs[$];

  task automatic addVec(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] expRes, input int expLat, input string name);
    vecT v;
    v.va = va; v.vb = vb; v.expRes = expRes; v.expLat = expLat; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Launch one op, measure edges from accept to out_valid, then retire it.
  task automatic doOp(input logic [31:0] av, input logic [31:0] bv,
                      input string name, output logic [31:0] res, output int lat);
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    res = result;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, " retired"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          waitCnt;

    addVec(32'h40400000, 32'h3F800000, 32'h40000000,  3, "3.0-1.0");
    addVec(32'h3F800000, 32'h3F800000, 32'h00000000,  2, "1.0-1.0");
    addVec(32'h80000000, 32'h00000000, 32'h80000000,  1, "-0-+0");
    addVec(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 27, "1-2^-24");
    addVec(32'h7F800000, 32'h7F800000, 32'h7FC00000,  1, "inf-inf");
    addVec(32'h7F800000, 32'h3F800000, 32'h7F800000,  1, "inf-1");
    addVec(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F7FFFFF,  3, "max+max ovf");
    addVec(32'h3F800000, 32'h4B800000, 32'hCB7FFFFF, 27, "1-2^24");
    addVec(32'h3F800000, 32'hBF800000, 32'h40000000,  3, "1+1 carry");
    addVec(32'h40000000, 32'h40400000, 32'hBF800000,  3, "2.0-3.0");
    addVec(32'h7F800001, 32'h3F800000, 32'h7FC00000,  1, "nan-1");
    addVec(32'hFF800000, 32'hFF800000, 32'h7FC00000,  1, "-inf--inf");
    addVec(32'h7F800000, 32'hFF800000, 32'h7F800000,  1, "inf--inf");
    addVec(32'h3F800000, 32'h7F800000, 32'hFF800000,  1, "1-inf");
    addVec(32'h80400000, 32'h00000001, 32'h80000000,  1, "ftz denorms");
    addVec(32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 29, "1-2^-30 sticky");
    addVec(32'h3F800000, 32'hB0800000, 32'h3F800000, 28, "1+2^-30 sticky");
    addVec(32'h00800000, 32'h00800001, 32'h80000000,  3, "underflow");
    addVec(32'h3F800000, 32'hBF000000, 32'h3FC00000,  3, "1+0.5");
    addVec(32'h00000000, 32'h3F800000, 32'hBF800000, 28, "0-1");

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      doOp(vecs[i].va, vecs[i].vb, vecs[i].name, res, lat);
      check({vecs[i].name, " result"}, res, vecs[i].expRes);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].expLat));
    end

    // Backpressure: result held, new requests ignored while DONE waits.
    @(negedge clk);
    a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 32'h3FC00000; b = 32'h3F000000;
    waitCnt = 0;
    while (!out_valid && waitCnt < 100) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    check("bp out_valid", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp held result", result, 32'h40000000);
      check("bp held flags", {29'd0, in_ready, out_valid, busy}, 32'd3);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp retire flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    doOp(32'h3FC00000, 32'h3F000000, "bp next", res, lat);
    check("bp next result", res, 32'h3F800000);
    check("bp next latency", 32'(lat), 32'd3);

    // Reset while aligning (d = 20) aborts the op without any output.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h35800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-op busy", {30'd0, busy, out_valid}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post-abort idle", {29'd0, in_ready, out_valid, busy}, 32'd4);
    doOp(32'h40400000, 32'h3F800000, "post-abort", res, lat);
    check("post-abort result", res, 32'h40000000);
    check("post-abort latency", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
